inst_buffer: RTL

// - Instruction buffer: the consumer end of the fetch-stage ib_valid/ib_ready handshake.
// - Queues {pc, inst, excp, excp_num} entries from fetch and hands them to decode in order.
// - Decouples fetch from decode stalls; drops all contents on pipeline flush, exception or ertn.

---
 rtl/inst_buffer_pkg.sv | 19 +
 rtl/inst_buffer.sv | 94 +++++++++
 2 files changed

// File: rtl/inst_buffer_pkg.sv
// Shared types and widths for the instruction buffer.
// Defines the queued entry layout {excp_num, excp, pc, inst} and default depth.
// Imported by inst_buffer and available to anything that builds or inspects entries.
package inst_buffer_pkg;

  localparam int EXCP_NUM_W = 4;
  localparam int PC_W       = 32;
  localparam int INST_W     = 32;
  localparam int IB_DEPTH   = 8;

  // One queued fetch packet; 69 bits, exception fields ride with their pc/inst.
  typedef struct packed {
    logic [EXCP_NUM_W-1:0] excp_num;
    logic                  excp;
    logic [PC_W-1:0]       pc;
    logic [INST_W-1:0]     inst;
  } ib_entry_t;

endpackage

// File: rtl/inst_buffer.sv
// Instruction buffer between fetch and decode: in-order circular queue of DEPTH entries.
// Latency: an entry pushed in cycle N reaches the head in cycle N+1 at the earliest (no fall-through).
// Backpressure: ib_ready drops when full or redirecting; a pop never frees a slot in the same cycle.
module inst_buffer
  import inst_buffer_pkg::*;
#(
  parameter int DEPTH = IB_DEPTH,
  parameter int PTR_W = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  flush,
  input  logic                  excp_flush,
  input  logic                  ertn_flush,
  input  logic                  ib_valid,
  output logic                  ib_ready,
  input  logic [PC_W-1:0]       pc_i,
  input  logic [INST_W-1:0]     inst_i,
  input  logic                  excp_i,
  input  logic [EXCP_NUM_W-1:0] excp_num_i,
  output logic                  id_valid,
  input  logic                  id_ready,
  output logic [PC_W-1:0]       pc_o,
  output logic [INST_W-1:0]     inst_o,
  output logic                  excp_o,
  output logic [EXCP_NUM_W-1:0] excp_num_o,
  output logic [PTR_W:0]        count
);

  ib_entry_t        mem_q [DEPTH];
  logic [PTR_W:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR_W:0]   rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0] wr_idx, rd_idx;
  logic             empty, full;
  logic             flush_any, kill;
  logic             push, pop;
  ib_entry_t        wr_entry, head;

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  assign wr_idx = wr_ptr_q[PTR_W-1:0];
  assign rd_idx = rd_ptr_q[PTR_W-1:0];
  assign empty  = (wr_ptr_q == rd_ptr_q);
  assign full   = (wr_idx == rd_idx) && (wr_ptr_q[PTR_W] != rd_ptr_q[PTR_W]);
  assign count  = wr_ptr_q - rd_ptr_q;

  // Reset mid-traffic is treated like any redirect so no handshake completes while it is high.
  assign flush_any = flush | excp_flush | ertn_flush;
  assign kill      = flush_any | reset;

  assign ib_ready = !full && !kill;
  assign id_valid = !empty && !kill;
  assign push     = ib_valid && ib_ready;
  assign pop      = id_valid && id_ready;

  assign wr_entry = '{excp_num: excp_num_i, excp: excp_i, pc: pc_i, inst: inst_i};
  assign head     = mem_q[rd_idx];

  assign pc_o       = head.pc;
  assign inst_o     = head.inst;
  assign excp_o     = head.excp;
  assign excp_num_o = head.excp_num;

  // Next pointer values: a redirect rewinds both pointers, otherwise each advances on its handshake.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (flush_any) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
    end else begin
      wr_ptr_d = wr_ptr_q + {{PTR_W{1'b0}}, push};
      rd_ptr_d = rd_ptr_q + {{PTR_W{1'b0}}, pop};
    end
  end

  // Pointer registers; only the pointers are cleared, stale entries stay in the array.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Entry storage: written only on an accepted push, never reset.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_idx] <= wr_entry;
    end
  end

endmodule
